// File: rtl/msk_and_hpc2_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : msk_and_hpc2_pipe_if
// Brief    : Handshake and share bus for the pipelined HPC2 masked AND gadget.
// Revision : 1.0 - initial release
// ============================================================================
interface msk_and_hpc2_pipe_if #(
   parameter int D = 2,
   parameter int W = 1
);
   localparam int R = D * (D - 1) / 2;

   logic             in_valid;
   logic             in_ready;
   logic [D*W-1:0]   inb;
   logic [W*R-1:0]   rnd;
   logic             a_req;
   logic [D*W-1:0]   ina;
   logic             out_valid;
   logic             out_ready;
   logic [D*W-1:0]   out;

   modport slave (
      input  in_valid, inb, rnd, ina, out_ready,
      output in_ready, a_req, out_valid, out
   );

   modport master (
      output in_valid, inb, rnd, ina, out_ready,
      input  in_ready, a_req, out_valid, out
   );
endinterface
`default_nettype wire

// File: rtl/msk_and_hpc2_pipe.sv
`default_nettype none
// ============================================================================
// Module   : msk_and_hpc2_pipe
// Brief    : W-lane, D-share HPC2 masked AND with a two-stage valid/ready pipe.
// Revision : 1.0 - initial release
// ============================================================================
module msk_and_hpc2_pipe #(
   parameter int D = 2,
   parameter int W = 1
) (
   input wire                 clk,
   input wire                 rst_n,
   msk_and_hpc2_pipe_if.slave bus
);
   localparam int R  = D * (D - 1) / 2;
   localparam int NP = D * (D - 1);

   // Randomness bit shared by the unordered pair {i,j}.
   function automatic int ridx(input int i, input int j);
      int lo;
      int hi;
      lo = (i < j) ? i : j;
      hi = (i < j) ? j : i;
      return lo * D - lo * (lo + 1) / 2 + (hi - 1 - lo);
   endfunction

   function automatic int pidx(input int i, input int j);
      return i * (D - 1) + ((j < i) ? j : j - 1);
   endfunction

   logic adv;

   (* keep = "true", dont_touch = "true" *) logic           v1_q, v1_d;
   (* keep = "true", dont_touch = "true" *) logic           v2_q, v2_d;
   (* keep = "true", dont_touch = "true" *) logic [W*R-1:0] rnd_prev_q, rnd_prev_d;
   (* keep = "true", dont_touch = "true" *) logic [D*W-1:0] b_prev_q, b_prev_d;
   (* keep = "true", dont_touch = "true" *) logic [W-1:0]   v_q [NP];
   (* keep = "true", dont_touch = "true" *) logic [W-1:0]   v_d [NP];
   (* keep = "true", dont_touch = "true" *) logic [W-1:0]   u_q [NP];
   (* keep = "true", dont_touch = "true" *) logic [W-1:0]   u_d [NP];
   (* keep = "true", dont_touch = "true" *) logic [W-1:0]   w_q [NP];
   (* keep = "true", dont_touch = "true" *) logic [W-1:0]   w_d [NP];
   (* keep = "true", dont_touch = "true" *) logic [W-1:0]   aibi_q [D];
   (* keep = "true", dont_touch = "true" *) logic [W-1:0]   aibi_d [D];
   (* keep = "true", dont_touch = "true" *) logic [W-1:0]   r_cur  [NP];
   (* keep = "true", dont_touch = "true" *) logic [W-1:0]   r_prev [NP];
   (* keep = "true", dont_touch = "true" *) logic [D*W-1:0] out_w;

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         r_cur[p]  = '0;
         r_prev[p] = '0;
      end
      for (int i = 0; i < D; i++) begin
         for (int j = 0; j < D; j++) begin
            if (i != j) begin
               for (int k = 0; k < W; k++) begin
                  r_cur[pidx(i, j)][k]  = bus.rnd[k*R + ridx(i, j)];
                  r_prev[pidx(i, j)][k] = rnd_prev_q[k*R + ridx(i, j)];
               end
            end
         end
      end
   end

   // A single enable freezes every register, so a stall never corrupts the gadget.
   always_comb begin
      adv        = !(v2_q && !bus.out_ready);
      v1_d       = v1_q;
      v2_d       = v2_q;
      rnd_prev_d = rnd_prev_q;
      b_prev_d   = b_prev_q;
      for (int p = 0; p < NP; p++) begin
         v_d[p] = v_q[p];
         u_d[p] = u_q[p];
         w_d[p] = w_q[p];
      end
      for (int i = 0; i < D; i++) begin
         aibi_d[i] = aibi_q[i];
      end
      if (adv) begin
         v1_d       = bus.in_valid;
         v2_d       = v1_q;
         rnd_prev_d = bus.rnd;
         b_prev_d   = bus.inb;
         for (int i = 0; i < D; i++) begin
            aibi_d[i] = bus.ina[i*W +: W] & b_prev_q[i*W +: W];
            for (int j = 0; j < D; j++) begin
               if (i != j) begin
                  v_d[pidx(i, j)] = bus.inb[j*W +: W] ^ r_cur[pidx(i, j)];
                  u_d[pidx(i, j)] = ~bus.ina[i*W +: W] & r_prev[pidx(i, j)];
                  w_d[pidx(i, j)] = bus.ina[i*W +: W] & v_q[pidx(i, j)];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         rnd_prev_q <= '0;
         b_prev_q   <= '0;
         for (int p = 0; p < NP; p++) begin
            v_q[p] <= '0;
            u_q[p] <= '0;
            w_q[p] <= '0;
         end
         for (int i = 0; i < D; i++) begin
            aibi_q[i] <= '0;
         end
      end else begin
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         rnd_prev_q <= rnd_prev_d;
         b_prev_q   <= b_prev_d;
         for (int p = 0; p < NP; p++) begin
            v_q[p] <= v_d[p];
            u_q[p] <= u_d[p];
            w_q[p] <= w_d[p];
         end
         for (int i = 0; i < D; i++) begin
            aibi_q[i] <= aibi_d[i];
         end
      end
   end

   always_comb begin
      out_w = '0;
      for (int i = 0; i < D; i++) begin
         out_w[i*W +: W] = aibi_q[i];
         for (int j = 0; j < D; j++) begin
            if (i != j) begin
               out_w[i*W +: W] = out_w[i*W +: W] ^ u_q[pidx(i, j)] ^ w_q[pidx(i, j)];
            end
         end
      end
   end

   assign bus.in_ready  = adv;
   assign bus.a_req     = v1_q;
   assign bus.out_valid = v2_q;
   assign bus.out       = out_w;

endmodule
`default_nettype wire

// File: tb/tb_msk_and_hpc2_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_msk_and_hpc2_pipe
// Brief    : Scoreboard bench for the pipelined HPC2 masked AND (D=3, W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_msk_and_hpc2_pipe;
   localparam int D  = 3;
   localparam int W  = 4;
   localparam int R  = D * (D - 1) / 2;
   localparam int DW = D * W;
   localparam int WR = W * R;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   msk_and_hpc2_pipe_if #(.D(D), .W(W)) bus ();

   msk_and_hpc2_pipe #(.D(D), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [W-1:0]  exp_q[$];
   logic [DW-1:0] out_log[$];
   bit            s1_full;
   bit            o_full;
   logic [DW-1:0] cur_a;

   function automatic logic [W-1:0] unmask(input logic [DW-1:0] x);
      logic [W-1:0] acc;
      acc = '0;
      for (int i = 0; i < D; i++) acc = acc ^ x[i*W +: W];
      return acc;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock of stimulus; the expected product is queued when the item is accepted.
   task automatic drive(input bit v, input bit ordy, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [WR-1:0] r);
      bit exp_rdy;
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.inb       = b;
      bus.rnd       = r;
      bus.out_ready = ordy;
      bus.ina       = s1_full ? cur_a : DW'($urandom);
      #1;
      exp_rdy = !(o_full && !ordy);
      check("in_ready",  64'(bus.in_ready),  64'(exp_rdy));
      check("a_req",     64'(bus.a_req),     64'(s1_full));
      check("out_valid", 64'(bus.out_valid), 64'(o_full));
      if (exp_rdy) begin
         if (v) exp_q.push_back(unmask(a) & unmask(b));
         o_full  = s1_full;
         s1_full = v;
         if (v) cur_a = a;
      end
   endtask

   task automatic drive_rand(input bit v, input bit ordy);
      drive(v, ordy, DW'($urandom), DW'($urandom), WR'($urandom));
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) drive_rand(1'b0, 1'b1);
      @(negedge clk);
      #1;
   endtask

   initial begin : monitor
      logic [DW-1:0] prev_out;
      bit            prev_stall;
      prev_stall = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", 64'(bus.out_valid), 64'(1));
               check("stall_out",   64'(bus.out),       64'(prev_out));
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_out: got %0h expected none", bus.out);
               end else begin
                  check("result", 64'(unmask(bus.out)), 64'(exp_q.pop_front()));
               end
               out_log.push_back(bus.out);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = bus.out;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      bit            pat [7];
      logic [DW-1:0] fa [8];
      logic [DW-1:0] fb [8];
      logic [DW-1:0] runs [3][8];
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      int            diff;

      bus.in_valid  = 1'b0;
      bus.inb       = '0;
      bus.rnd       = '0;
      bus.ina       = '0;
      bus.out_ready = 1'b1;
      s1_full = 1'b0;
      o_full  = 1'b0;
      cur_a   = '0;

      #23;
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_a_req",     64'(bus.a_req),     64'(0));
      check("rst_out",       64'(bus.out),       64'(0));
      check("rst_in_ready",  64'(bus.in_ready),  64'(1));
      @(negedge clk);
      rst_n = 1'b1;

      // All 16 share-bit combinations of two a-shares and two b-shares, lane-replicated.
      for (int c = 0; c < 16; c++) begin
         a = '0;
         b = '0;
         a[0*W +: W] = {W{c[0]}};
         a[1*W +: W] = {W{c[1]}};
         b[0*W +: W] = {W{c[2]}};
         b[1*W +: W] = {W{c[3]}};
         drive(1'b1, 1'b1, a, b, WR'($urandom));
      end
      drain(3);

      for (int n = 0; n < 1000; n++) drive_rand(1'b1, 1'b1);
      drain(3);

      for (int n = 0; n < 3; n++) drive_rand(1'b1, 1'b1);
      for (int n = 0; n < 5; n++) drive_rand(1'b1, 1'b0);
      for (int n = 0; n < 4; n++) drive_rand(1'b1, 1'b1);
      drain(3);

      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         drive_rand(pat[i], 1'b1);
         check("bubble_valid", 64'(bus.out_valid), 64'((i >= 2) ? pat[i-2] : 1'b0));
      end
      drain(2);

      drive_rand(1'b1, 1'b1);
      drive_rand(1'b1, 1'b1);
      drive_rand(1'b1, 1'b0);
      check("pre_rst_a_req", 64'(bus.a_req), 64'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("mid_rst_a_req",     64'(bus.a_req),     64'(0));
      check("mid_rst_out",       64'(bus.out),       64'(0));
      exp_q.delete();
      s1_full = 1'b0;
      o_full  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         drive_rand(1'b0, 1'b1);
         check("post_rst_out_valid", 64'(bus.out_valid), 64'(0));
      end

      for (int n = 0; n < 8; n++) begin
         fa[n] = DW'($urandom);
         fb[n] = DW'($urandom);
      end
      for (int s = 0; s < 3; s++) begin
         out_log.delete();
         for (int n = 0; n < 8; n++) drive(1'b1, 1'b1, fa[n], fb[n], WR'($urandom));
         drain(3);
         check("seed_run_count", 64'(out_log.size()), 64'(8));
         for (int n = 0; n < 8; n++) runs[s][n] = (n < out_log.size()) ? out_log[n] : '0;
      end
      diff = 0;
      for (int s = 1; s < 3; s++) begin
         for (int n = 0; n < 8; n++) begin
            check("seed_unmasked", 64'(unmask(runs[s][n])), 64'(unmask(fa[n]) & unmask(fb[n])));
            if (runs[s][n] != runs[0][n]) diff++;
         end
      end
      check("seed_shares_differ", 64'(diff > 0), 64'(1));

      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/msk_and_hpc2_pipe.md
Name: msk_and_hpc2_pipe

Overview:
W-lane, d-share HPC2 masked AND gadget with a valid/ready pipeline around it.
Two register stages. B-shares and fresh randomness enter at stage 0. A-shares are consumed one cycle later, when stage 1 holds the item.
Sits in masked S-box datapaths where upstream/downstream stalls must not corrupt the gadget and bubbles must not consume randomness.

Parameters:
d, 2, number of shares (>=2)
W, 1, number of independent parallel AND lanes
R, d*(d-1)/2, random bits per lane (derived localparam, not overridable)

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  b-shares and rnd valid this cycle
in_ready  output  1  stage 0 can accept
inb  input  d*W  b-shares; share i, lane k at bit i*W+k
rnd  input  W*R  fresh randomness; lane k uses [k*R +: R], consumed with inb
a_req  output  1  stage 1 occupied; ina must be driven and held stable while a_req=1
ina  input  d*W  a-shares, same layout as inb; sampled when stage 1 advances
out_valid  output  1  out holds a result
out_ready  input  1  downstream accepts out
out  output  d*W  product shares, same layout

Behaviour:
- Reset (async assert, sync deassert by the integrator) clears all registers to 0: v1=v2=0, out=0, out_valid=0, a_req=0.
- adv = !(v2 && !out_ready). Pipeline-wide enable; every data register updates only when adv=1. This is the en gating of the HPC2 gadget.
- in_ready = adv. Accept when in_valid && in_ready.
- On adv, per lane k and pair (i<j), r_ij = rnd[k*R + i*d - i*(i+1)/2 + (j-1-i)] and r_ji = r_ij.
- Stage 0->1, on adv:
  - v1 <= in_valid
  - rnd_prev <= rnd
  - b_prev <= inb
  - v_ij <= inb_j ^ r_ij for all j != i
- Stage 1->2, on adv:
  - v2 <= v1
  - aibi_i <= ina_i & b_prev_i
  - u_ij <= ~ina_i & rnd_prev_ij
  - w_ij <= ina_i & v_ij
- out_i = aibi_i ^ XOR_j(u_ij) ^ XOR_j(w_ij). Pure XOR of registers, no other logic.
- out_valid = v2; a_req = v1.
- Latency: inb accepted at cycle t -> ina consumed at cycle t+1 -> out_valid at t+2, with no stalls. Throughput is 1 item/cycle.
- Bubbles: when in_valid=0 and adv=1, the data registers still load whatever is on inb/rnd. v1 marks the stage empty and the result is discarded. Upstream need not supply fresh rnd on bubble cycles.
- Stall: when adv=0, every register holds, including rnd_prev and b_prev.
  - ina must stay stable for the whole stall while a_req=1.
  - out stays stable while out_valid && !out_ready.
- Unmasked result per lane: XOR_i out_i = (XOR_i ina_i) & (XOR_i inb_i) for any rnd.
- Security: no share-crossing logic outside the listed terms. Every intermediate net and register carries the keep/preserve attributes used by the gadget family. Synthesis must not merge u/v/w terms.
- Reset mid-operation: in-flight items are dropped, with no partial outputs and no out_valid pulse after deassertion until a new accept has propagated.
- d=2 with W=1 is functionally equivalent to the existing single-bit HPC2 AND with en=adv.

Test Plan:
- d=2, W=1, rnd=1, no backpressure: inb shares {1,0}, then ina shares {0,1} one cycle later -> out_valid at t+2, out0^out1=1. Repeat over all 16 share combinations -> unmasked out = a&b for every case.
- d=3, W=4, random rnd each cycle, 1000 back-to-back items -> one out_valid per cycle after a 2-cycle fill; every lane's unmasked out equals a&b; in_ready constant 1.
- Backpressure: hold out_ready=0 for 5 cycles with v2=1 -> in_ready=0, out bit-identical each cycle, a_req held. Release -> stream resumes with no loss or duplicate, in order.
- Bubbles: in_valid pattern 1,0,1,1,0 with rnd=X on the idle cycles -> out_valid pattern 1,0,1,1,0 delayed by 2 cycles, with correct results.
- Reset: assert rst_n=0 while v1=v2=1 -> out_valid=0, a_req=0, out=0 immediately. After release with in_valid=0 -> out_valid stays 0.
- Randomness independence: the same a/b stream with 3 different rnd seeds -> identical unmasked results; individual output shares differ.
